// File: rtl/lsu_split.sv
// Registered load/store unit: one byte/half/word access as one or two aligned bus beats, with bus timeout.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses; otherwise they return invalid without a bus beat.
module lsu_split #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en_i,
   input  logic                  r_en_i,
   input  logic [1:0]            type_i,
   input  logic                  sign_extend_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic                  invalid_o,
   output logic [31:0]           rdata_o,
   output logic                  dmem_valid_o,
   input  logic                  dmem_ready_i,
   output logic [ADDR_WIDTH-1:0] dmem_addr_o,
   output logic [31:0]           dmem_wdata_o,
   output logic [3:0]            dmem_we_o,
   input  logic [31:0]           dmem_rdata_i
);

   // state | meaning
   // IDLE  | ready for a request
   // BEAT0 | first (or only) bus beat, word containing addr
   // BEAT1 | second beat of a split access, next word
   // RESP  | done pulse, invalid if misaligned/bad type/timeout
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BEAT0 = 2'd1;
   localparam logic [1:0] S_BEAT1 = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [1:0] DATA_BYTE      = 2'b00;
   localparam logic [1:0] DATA_HALF_WORD = 2'b01;
   localparam logic [1:0] DATA_WORD      = 2'b10;

   localparam int CW = (CNT_WIDTH > 0) ? CNT_WIDTH : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            type_q, type_d;
   logic                  sext_q, sext_d;
   logic                  we_dir_q, we_dir_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           asm_q, asm_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  inv_q, inv_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [2:0]            sz_q;
   logic                  split;
   logic                  beat_active;
   logic [ADDR_WIDTH-1:0] word0;
   logic [31:0]           asm_cap;
   logic [31:0]           ext;

   function automatic logic [2:0] size_of(input logic [1:0] t);
      case (t)
         DATA_BYTE:      return 3'd1;
         DATA_HALF_WORD: return 3'd2;
         DATA_WORD:      return 3'd4;
         default:        return 3'd0;
      endcase
   endfunction

   function automatic logic is_bad(input logic [1:0] t, input logic [1:0] off);
      if (t == 2'b11) return 1'b1;
`ifdef LSU_MISALIGNED_SPLIT_EN
      return (off == 2'b11) && 1'b0;
`else
      return ((4'(off) + 4'(size_of(t))) > 4'd4) || ((t == DATA_HALF_WORD) && off[0]);
`endif
   endfunction

   assign sz_q        = size_of(type_q);
   assign split       = (4'(addr_q[1:0]) + 4'(sz_q)) > 4'd4;
   assign beat_active = (state_q == S_BEAT0) || (state_q == S_BEAT1);
   assign word0       = {addr_q[ADDR_WIDTH-1:2], 2'b00};

   assign ready_o      = (state_q == S_IDLE);
   assign done_o       = (state_q == S_RESP);
   assign invalid_o    = done_o & inv_q;
   assign dmem_valid_o = beat_active;
   assign dmem_addr_o  = (state_q == S_BEAT1) ? word0 + ADDR_WIDTH'(4) : word0;

   // Lane k holds the memory byte at word offset k; j is the value byte that maps onto it this beat.
   always_comb begin
      int j;
      j            = 0;
      dmem_we_o    = 4'h0;
      dmem_wdata_o = 32'h0;
      asm_cap      = asm_q;
      for (int k = 0; k < 4; k++) begin
         if (state_q == S_BEAT1) j = k + 4 - int'(addr_q[1:0]);
         else                    j = k - int'(addr_q[1:0]);
         if (beat_active && (j >= 0) && (j < int'(sz_q))) begin
            dmem_we_o[3-k] = we_dir_q;
            if (we_dir_q) dmem_wdata_o[31-8*k -: 8] = wdata_q[8*j +: 8];
            asm_cap[8*j +: 8] = dmem_rdata_i[31-8*k -: 8];
         end
      end
   end

   always_comb begin
      ext = asm_q;
      if (sz_q == 3'd1)      ext[31:8]  = sext_q ? {24{asm_q[7]}}  : 24'h0;
      else if (sz_q == 3'd2) ext[31:16] = sext_q ? {16{asm_q[15]}} : 16'h0;
   end

   assign rdata_o = (done_o && !inv_q && !we_dir_q) ? ext : rdata_q;
   assign rdata_d = rdata_o;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      type_d   = type_q;
      sext_d   = sext_q;
      we_dir_d = we_dir_q;
      wdata_d  = wdata_q;
      asm_d    = asm_q;
      inv_d    = inv_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (w_en_i || r_en_i) begin
               addr_d   = addr_i;
               type_d   = type_i;
               sext_d   = sign_extend_i;
               we_dir_d = w_en_i;
               wdata_d  = wdata_i;
               asm_d    = 32'h0;
               cnt_d    = '0;
               inv_d    = is_bad(type_i, addr_i[1:0]);
               state_d  = inv_d ? S_RESP : S_BEAT0;
            end
         end
         S_BEAT0, S_BEAT1: begin
            if (dmem_ready_i) begin
               asm_d   = asm_cap;
               cnt_d   = '0;
               state_d = (state_q == S_BEAT0 && split) ? S_BEAT1 : S_RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
               inv_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         type_q   <= 2'b00;
         sext_q   <= 1'b0;
         we_dir_q <= 1'b0;
         wdata_q  <= 32'h0;
         asm_q    <= 32'h0;
         rdata_q  <= 32'h0;
         inv_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         type_q   <= type_d;
         sext_q   <= sext_d;
         we_dir_q <= we_dir_d;
         wdata_q  <= wdata_d;
         asm_q    <= asm_d;
         rdata_q  <= rdata_d;
         inv_q    <= inv_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split: vector table for single accesses, hand sequences for timeout and reset abort.
module tb_lsu_split;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        w_en_i, r_en_i, sign_extend_i;
   logic [1:0]  type_i;
   logic [31:0] addr_i, wdata_i;
   logic        ready_o, done_o, invalid_o;
   logic [31:0] rdata_o;
   logic        dmem_valid_o, dmem_ready_i;
   logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
   logic [3:0]  dmem_we_o;

   logic        bus_rdy;
   logic [31:0] cur_w0, cur_rd0, cur_rd1;

   int checks = 0;
   int errors = 0;

   lsu_split #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .w_en_i(w_en_i), .r_en_i(r_en_i), .type_i(type_i),
      .sign_extend_i(sign_extend_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .ready_o(ready_o), .done_o(done_o), .invalid_o(invalid_o), .rdata_o(rdata_o),
      .dmem_valid_o(dmem_valid_o), .dmem_ready_i(dmem_ready_i), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_we_o(dmem_we_o), .dmem_rdata_i(dmem_rdata_i)
   );

   always #5 clk = ~clk;

   always_comb begin
      dmem_ready_i = bus_rdy & dmem_valid_o;
      dmem_rdata_i = (dmem_addr_o == cur_w0) ? cur_rd0 : cur_rd1;
   end

   typedef struct {
      logic        st;
      logic        ld;
      logic [1:0]  typ;
      logic        sx;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic        bus;
      logic [31:0] e_addr;
      logic [3:0]  e_we;
      logic [31:0] e_wdata;
      logic        e_inv;
      int          e_lat;
      logic        chk_rd;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          cyc;
      logic        seen, got_done;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  s_we;
      cur_w0  = {v.addr[31:2], 2'b00};
      cur_rd0 = v.rd0;
      cur_rd1 = v.rd1;
      w_en_i = v.st; r_en_i = v.ld; type_i = v.typ; sign_extend_i = v.sx;
      addr_i = v.addr; wdata_i = v.wdata;
      chk($sformatf("v%0d_ready_at_accept", idx), 32'(ready_o), 32'd1);
      tick();
      w_en_i = 1'b0; r_en_i = 1'b0;
      addr_i = 32'hFFFF_FFFF; wdata_i = 32'h5A5A_5A5A; type_i = 2'b11;
      seen = 1'b0; got_done = 1'b0; s_addr = '0; s_we = '0; s_wdata = '0;
      cyc = 1;
      while (cyc <= 8) begin
         if (dmem_valid_o && !seen) begin
            seen = 1'b1; s_addr = dmem_addr_o; s_we = dmem_we_o; s_wdata = dmem_wdata_o;
         end
         if (done_o) begin
            got_done = 1'b1;
            break;
         end
         tick();
         cyc++;
      end
      chk($sformatf("v%0d_done_seen", idx), 32'(got_done), 32'd1);
      if (got_done) begin
         chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.e_lat));
         chk($sformatf("v%0d_invalid", idx), 32'(invalid_o), 32'(v.e_inv));
         if (v.chk_rd) chk($sformatf("v%0d_rdata", idx), rdata_o, v.e_rd);
      end
      chk($sformatf("v%0d_bus_used", idx), 32'(seen), 32'(v.bus));
      if (v.bus && seen) begin
         chk($sformatf("v%0d_beat0_addr", idx), s_addr, v.e_addr);
         chk($sformatf("v%0d_beat0_we", idx), 32'(s_we), 32'(v.e_we));
         chk($sformatf("v%0d_beat0_wdata", idx), s_wdata, v.e_wdata);
      end
      tick();
      chk($sformatf("v%0d_ready_after", idx), 32'(ready_o), 32'd1);
      chk($sformatf("v%0d_done_single", idx), 32'(done_o), 32'd0);
   endtask

   initial begin
      int cyc;
      int vcnt;
      logic got_done;

      //           st ld typ    sx addr          wdata          rd0            rd1           bus e_addr        e_we     e_wdata        inv lat chk e_rd
      vecs[0]  = '{0, 1, 2'b10, 0, 32'h100, 32'h0,        32'h11223344, 32'h0,        1, 32'h100, 4'b0000, 32'h0,        0, 2, 1, 32'h44332211};
      vecs[1]  = '{1, 0, 2'b00, 0, 32'h103, 32'h000000A5, 32'h0,        32'h0,        1, 32'h100, 4'b0001, 32'h000000A5, 0, 2, 1, 32'h44332211};
      vecs[2]  = '{0, 1, 2'b01, 1, 32'h202, 32'h0,        32'h0000FF80, 32'h0,        1, 32'h200, 4'b0000, 32'h0,        0, 2, 1, 32'hFFFF80FF};
      vecs[3]  = '{0, 1, 2'b01, 0, 32'h202, 32'h0,        32'h0000FF80, 32'h0,        1, 32'h200, 4'b0000, 32'h0,        0, 2, 1, 32'h000080FF};
      vecs[4]  = '{1, 0, 2'b10, 0, 32'h204, 32'hDEADBEEF, 32'h0,        32'h0,        1, 32'h204, 4'b1111, 32'hEFBEADDE, 0, 2, 1, 32'h000080FF};
      vecs[5]  = '{0, 1, 2'b00, 1, 32'h301, 32'h0,        32'h12F45678, 32'h0,        1, 32'h300, 4'b0000, 32'h0,        0, 2, 1, 32'hFFFFFFF4};
      vecs[6]  = '{0, 1, 2'b00, 0, 32'h302, 32'h0,        32'h12F45678, 32'h0,        1, 32'h300, 4'b0000, 32'h0,        0, 2, 1, 32'h00000056};
      vecs[7]  = '{1, 0, 2'b01, 0, 32'h402, 32'h0000BEEF, 32'h0,        32'h0,        1, 32'h400, 4'b0011, 32'h0000EFBE, 0, 2, 0, 32'h0};
      vecs[8]  = '{0, 1, 2'b11, 0, 32'h500, 32'h0,        32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        1, 1, 0, 32'h0};
`ifdef LSU_MISALIGNED_SPLIT_EN
      vecs[9]  = '{0, 1, 2'b10, 0, 32'h103, 32'h0,        32'h000000AA, 32'hBBCCDD00, 1, 32'h100, 4'b0000, 32'h0,        0, 3, 1, 32'hDDCCBBAA};
      vecs[10] = '{0, 1, 2'b01, 0, 32'h201, 32'h0,        32'h00ABCD00, 32'h0,        1, 32'h200, 4'b0000, 32'h0,        0, 2, 1, 32'h0000CDAB};
`else
      vecs[9]  = '{0, 1, 2'b10, 0, 32'h103, 32'h0,        32'h000000AA, 32'hBBCCDD00, 0, 32'h0,   4'b0000, 32'h0,        1, 1, 0, 32'h0};
      vecs[10] = '{0, 1, 2'b01, 0, 32'h201, 32'h0,        32'h00ABCD00, 32'h0,        0, 32'h0,   4'b0000, 32'h0,        1, 1, 0, 32'h0};
`endif
      vecs[11] = '{1, 1, 2'b00, 0, 32'h600, 32'h00000077, 32'h0,        32'h0,        1, 32'h600, 4'b1000, 32'h77000000, 0, 2, 0, 32'h0};

      rst_n = 1'b0; w_en_i = 1'b0; r_en_i = 1'b0; type_i = 2'b00; sign_extend_i = 1'b0;
      addr_i = 32'h0; wdata_i = 32'h0; bus_rdy = 1'b1;
      cur_w0 = 32'h0; cur_rd0 = 32'h0; cur_rd1 = 32'h0;
      tick(); tick(); tick();
      rst_n = 1'b1;

      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_invalid", 32'(invalid_o), 32'd0);
      chk("rst_valid", 32'(dmem_valid_o), 32'd0);
      chk("rst_we", 32'(dmem_we_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'h0);

      vcnt = 12;
      for (int i = 0; i < vcnt; i++) run_vec(i, vecs[i]);

      // Bus stalls forever: beat held for 4 cycles, then invalid done.
      bus_rdy = 1'b0;
      cur_w0 = 32'h700; cur_rd0 = 32'h0; cur_rd1 = 32'h0;
      r_en_i = 1'b1; type_i = 2'b10; addr_i = 32'h700;
      tick();
      r_en_i = 1'b0;
      cyc = 1; got_done = 1'b0;
      while (cyc <= 10) begin
         if (done_o) begin
            got_done = 1'b1;
            break;
         end
         chk($sformatf("to_valid_c%0d", cyc), 32'(dmem_valid_o), 32'd1);
         chk($sformatf("to_addr_c%0d", cyc), dmem_addr_o, 32'h700);
         tick();
         cyc++;
      end
      chk("to_done_seen", 32'(got_done), 32'd1);
      chk("to_done_cycle", 32'(cyc), 32'd5);
      chk("to_invalid", 32'(invalid_o), 32'd1);
      chk("to_valid_dropped", 32'(dmem_valid_o), 32'd0);
      tick();
      chk("to_ready_after", 32'(ready_o), 32'd1);
      chk("to_done_after", 32'(done_o), 32'd0);

      // Reset in the middle of a stalled beat aborts without a done pulse.
      r_en_i = 1'b1; type_i = 2'b10; addr_i = 32'h800;
      tick();
      r_en_i = 1'b0;
      chk("ra_beat_valid", 32'(dmem_valid_o), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("ra_valid_after_rst", 32'(dmem_valid_o), 32'd0);
      chk("ra_ready_after_rst", 32'(ready_o), 32'd1);
      chk("ra_done_after_rst", 32'(done_o), 32'd0);
      chk("ra_rdata_after_rst", rdata_o, 32'h0);
      rst_n = 1'b1;
      bus_rdy = 1'b1;
      tick();
      chk("ra_no_done_idle", 32'(done_o), 32'd0);
      run_vec(20, '{0, 1, 2'b10, 0, 32'h104, 32'h0, 32'hA1B2C3D4, 32'h0,
                    1, 32'h104, 4'b0000, 32'h0, 0, 2, 1, 32'hD4C3B2A1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
